// File: rtl/parity_check.sv
// Streaming even-parity checker.
// Each accepted word is checked once against its received parity bit and
// forwarded with a per-word error flag through a 2-entry skid buffer, so
// a word can be accepted every cycle even while downstream stalls. A sticky
// error flag and a saturating error counter report link health.
module parity_check #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_par,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_err,
    input  logic                     clr,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ZERO = {ERR_CNT_WIDTH{1'b0}};
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = {ERR_CNT_WIDTH{1'b1}};
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE  = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Even parity of a data word: the correct parity bit equals the XOR of all bits.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    state_t                   r_state;
    logic                     r_s_ready;
    logic                     r_m_valid;
    logic [DATA_WIDTH-1:0]    r_main_data;
    logic                     r_main_err;
    logic [DATA_WIDTH-1:0]    r_skid_data;
    logic                     r_skid_err;
    logic                     r_err_sticky;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    logic w_accept;
    logic w_pop;
    logic w_err;
    logic w_err_accept;

    assign w_accept     = s_valid & r_s_ready;
    assign w_pop        = r_m_valid & m_ready;
    assign w_err        = even_parity(s_data) ^ s_par;
    assign w_err_accept = w_accept & w_err;

    assign s_ready    = r_s_ready;
    assign m_valid    = r_m_valid;
    assign m_data     = r_main_data;
    assign m_err      = r_main_err;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

    // Skid-buffer state machine: moves words main/skid and drives the handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_s_ready   <= 1'b1;
            r_m_valid   <= 1'b0;
            r_main_data <= DATA_ZERO;
            r_main_err  <= 1'b0;
            r_skid_data <= DATA_ZERO;
            r_skid_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= s_data;
                        r_main_err  <= w_err;
                        r_m_valid   <= 1'b1;
                        r_s_ready   <= 1'b1;
                        r_state     <= ST_BUSY;
                    end else begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_pop) begin
                        r_main_data <= s_data;
                        r_main_err  <= w_err;
                        r_state     <= ST_BUSY;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new word in the skid slot.
                        r_skid_data <= s_data;
                        r_skid_err  <= w_err;
                        r_s_ready   <= 1'b0;
                        r_state     <= ST_FULL;
                    end else if (w_pop) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_EMPTY;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_main_data <= r_skid_data;
                        r_main_err  <= r_skid_err;
                        r_s_ready   <= 1'b1;
                        r_state     <= ST_BUSY;
                    end else begin
                        r_state <= ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty buffer.
                    r_state   <= ST_EMPTY;
                    r_s_ready <= 1'b1;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    // Error status: sticky flag and saturating counter; an erroneous accept wins over clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= CNT_ZERO;
        end else if (clr) begin
            r_err_sticky <= w_err_accept;
            r_err_cnt    <= w_err_accept ? CNT_ONE : CNT_ZERO;
        end else if (w_err_accept) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != CNT_MAX) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end else begin
            r_err_sticky <= r_err_sticky;
            r_err_cnt    <= r_err_cnt;
        end
    end

endmodule

// File: doc/parity_check.md
Name: parity_check

Overview:
- Streaming even-parity checker; the receive-side counterpart of the even-parity generator.
- Accepts a data word plus its transmitted parity bit over a valid/ready interface, recomputes even parity and forwards the word tagged with a per-word error flag.
- Keeps a sticky error flag and a saturating error counter for status readout.
- Sits between a link or deserializer and downstream consumers; fully registered, full throughput under backpressure via a 2-entry skid buffer.

Parameters:
- DATA_WIDTH, 8, width of the data word (>=1).
- ERR_CNT_WIDTH, 16, width of the error counter (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  checker can accept; registered.
- s_data  input  DATA_WIDTH  upstream data word.
- s_par  input  1  received even-parity bit for s_data.
- m_valid  output  1  downstream word valid.
- m_ready  input  1  downstream accepts.
- m_data  output  DATA_WIDTH  forwarded data word.
- m_err  output  1  parity error for the word on m_data.
- clr  input  1  clears err_sticky and err_cnt.
- err_sticky  output  1  set on any accepted erroneous word.
- err_cnt  output  ERR_CNT_WIDTH  count of accepted erroneous words, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge): m_valid=0, m_data=0, m_err=0, s_ready=1, err_sticky=0, err_cnt=0, skid contents=0. s_valid, m_ready and clr are ignored while rst_n=0. Reset mid-operation discards buffered words.
- Accept = s_valid & s_ready. Pop = m_valid & m_ready.
- Error computation at accept: err = (XOR of all s_data bits) XOR s_par. Even parity means the correct s_par equals the XOR of the data bits. err is stored with the word; the check happens exactly once per accepted word, regardless of stalls.
- States:
  - EMPTY: m_valid=0, s_ready=1.
  - BUSY: m_valid=1, s_ready=1, main register holds a word.
  - FULL: m_valid=1, s_ready=0, main and skid registers both hold a word.
- EMPTY transitions: on accept, load main, go to BUSY.
- BUSY transitions:
  - Accept and pop: load main with the new word, stay in BUSY.
  - Accept without pop: load skid, go to FULL.
  - Pop without accept: go to EMPTY.
  - Neither: hold.
- FULL transitions: on pop, main <= skid, go to BUSY. No accept is possible in FULL.
- Latency: a word accepted at edge N is presented on m_data/m_err after edge N (1 cycle).
- Ordering: strictly in order; no loss and no duplication. m_data/m_err are stable while m_valid=1 and m_ready=0.
- m_data/m_err keep their last values when m_valid=0.
- err_cnt:
  - Increments by 1 on each accept with err=1.
  - Saturates at all-ones and never wraps.
- err_sticky: set on accept with err=1; holds until clr or reset.
- clr: clears err_cnt and err_sticky at the next edge. If clr and an erroneous accept occur in the same cycle, the result is err_cnt=1 and err_sticky=1.
- clr has no effect on the data path.

Test Plan:
- DATA_WIDTH=8, s_data=8'hA5, s_par=0, m_ready=1 -> next cycle m_valid=1, m_data=8'hA5, m_err=0; err_cnt stays 0, err_sticky stays 0.
- s_data=8'h01, s_par=0 -> m_err=1, err_sticky=1, err_cnt=1. Then s_data=8'h01, s_par=1 -> m_err=0, err_cnt remains 1.
- m_ready=0, s_valid=1 continuously with words 8'h11, 8'h22, 8'h33:
  - Two words are accepted, then s_ready=0 with 8'h33 held on the input.
  - m_data holds 8'h11 stable.
  - Raising m_ready yields 8'h11, 8'h22, 8'h33 on consecutive cycles, with no gaps or duplicates.
- ERR_CNT_WIDTH=4, 17 consecutive bad-parity words -> err_cnt reaches 4'hF and stays 4'hF; err_sticky=1.
- err_cnt=5, clr=1 in the same cycle as a bad-parity accept -> err_cnt=1, err_sticky=1. Next cycle clr=1 alone -> err_cnt=0, err_sticky=0.
- In FULL state, assert rst_n=0 for one cycle -> m_valid=0, s_ready=1, err_cnt=0, err_sticky=0; the buffered words never appear on m_data.
